// File: rtl/cordic_ctrl_if.sv
// cordic_ctrl_if -- bundles the request and result signals of cordic_ctrl.
//
// Handshake: a request is accepted on the rising edge where start = 1 and
// busy = 0. busy stays high from the accepting edge until the edge that
// leaves DONE. done pulses for exactly one cycle, and x_out/y_out/z_out are
// valid in that cycle. The outputs then hold until the next completion.
// A start raised while busy = 1 is dropped and is not queued.
//
// Signals:
//   start            request a rotation (sampled only while idle)
//   x_in, y_in       signed 19-bit initial vector
//   z_in             signed 9-bit target angle, 1 LSB = 1 degree
//   busy, done       status, see handshake above
//   x_out, y_out     signed 19-bit rotated vector (registered)
//   z_out            signed 9-bit residual angle (registered)
//   dbg_state        FSM state encoding (0 IDLE, 1 RUN, 2 DONE)
//   dbg_iter         current iteration index
interface cordic_ctrl_if;
  logic               start;
  logic signed [18:0] x_in;
  logic signed [18:0] y_in;
  logic signed [8:0]  z_in;
  logic               busy;
  logic               done;
  logic signed [18:0] x_out;
  logic signed [18:0] y_out;
  logic signed [8:0]  z_out;
  logic [1:0]         dbg_state;
  logic [2:0]         dbg_iter;

  modport master (
    output start, x_in, y_in, z_in,
    input  busy, done, x_out, y_out, z_out, dbg_state, dbg_iter
  );

  modport slave (
    input  start, x_in, y_in, z_in,
    output busy, done, x_out, y_out, z_out, dbg_state, dbg_iter
  );
endinterface

// File: rtl/cordic_ctrl.sv
// cordic_ctrl -- iterative CORDIC rotator in degrees.
//
// A single add/shift stage is reused for 8 iterations (i = 0..7). Each
// iteration rotates the working vector toward the target angle by
// +/- atan(2^-i). x and y wrap modulo 2^19 and z wraps modulo 2^9; nothing
// saturates. Results are copied to the output registers on the last
// iteration and then held.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  cordic_ctrl_if.slave (start/x_in/y_in/z_in in,
//        busy/done/x_out/y_out/z_out/dbg_state/dbg_iter out)
module cordic_ctrl (
  input  logic           clk,
  input  logic           rst,
  cordic_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         iter_q, iter_d;
  logic signed [18:0] x_q, x_d;
  logic signed [18:0] y_q, y_d;
  logic signed [8:0]  z_q, z_d;
  logic signed [18:0] xo_q, xo_d;
  logic signed [18:0] yo_q, yo_d;
  logic signed [8:0]  zo_q, zo_d;

  // Shared single-iteration datapath.
  logic signed [18:0] x_sh, y_sh;
  logic signed [18:0] x_nx, y_nx;
  logic signed [8:0]  z_nx;
  logic signed [8:0]  atan_v;

  always_comb begin
    atan_v = 9'sd0;
    case (iter_q)
      3'd0: atan_v = 9'sd45;
      3'd1: atan_v = 9'sd27;
      3'd2: atan_v = 9'sd14;
      3'd3: atan_v = 9'sd7;
      3'd4: atan_v = 9'sd4;
      3'd5: atan_v = 9'sd2;
      3'd6: atan_v = 9'sd1;
      3'd7: atan_v = 9'sd0;
      default: atan_v = 9'sd0;
    endcase
  end

  // Both shifts use the pre-update x and y.
  assign x_sh = x_q >>> iter_q;
  assign y_sh = y_q >>> iter_q;

  always_comb begin
    x_nx = x_q;
    y_nx = y_q;
    z_nx = z_q;
    if (z_q[8]) begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + atan_v;
    end else begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - atan_v;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.x_in;
          y_d     = bus.y_in;
          z_d     = bus.z_in;
          iter_d  = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d = x_nx;
        y_d = y_nx;
        z_d = z_nx;
        if (iter_q == 3'd7) begin
          // Last iteration: publish results; counter parks at 0 rather
          // than wrapping into another pass.
          xo_d    = x_nx;
          yo_d    = y_nx;
          zo_d    = z_nx;
          iter_d  = 3'd0;
          state_d = DONE;
        end else begin
          iter_d = iter_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q  <= 3'd0;
      x_q     <= 19'sd0;
      y_q     <= 19'sd0;
      z_q     <= 9'sd0;
      xo_q    <= 19'sd0;
      yo_q    <= 19'sd0;
      zo_q    <= 9'sd0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.x_out     = xo_q;
  assign bus.y_out     = yo_q;
  assign bus.z_out     = zo_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_iter  = iter_q;

endmodule
